// File: rtl/mul16_arbiter_if.sv
// Requester, response and shared-multiplier signal bundle of mul16_arbiter.
interface mul16_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    REQ_VALID;
  logic [N_REQ-1:0]    REQ_READY;
  logic [16*N_REQ-1:0] REQ_A;
  logic [16*N_REQ-1:0] REQ_B;
  logic [N_REQ-1:0]    REQ_TC;
  logic [15:0]         MUL_A;
  logic [15:0]         MUL_B;
  logic                MUL_TC;
  logic [31:0]         MUL_PRODUCT;
  logic [N_REQ-1:0]    RSP_VALID;
  logic [31:0]         RSP_PRODUCT;

  // Arbiter side
  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, REQ_TC, MUL_PRODUCT,
    output REQ_READY, MUL_A, MUL_B, MUL_TC, RSP_VALID, RSP_PRODUCT
  );

  // Requesters plus attached multiplier
  modport master (
    output REQ_VALID, REQ_A, REQ_B, REQ_TC, MUL_PRODUCT,
    input  REQ_READY, MUL_A, MUL_B, MUL_TC, RSP_VALID, RSP_PRODUCT
  );
endinterface

// File: rtl/mul16_arbiter.sv
// Round-robin sharing of one pipelined 16x16 multiplier among N_REQ requesters.
// Each issued operation carries its requester index down a tag pipeline that
// matches the multiplier latency, so products are routed back as one-cycle pulses.
module mul16_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           EN,
  mul16_arbiter_if.slave bus,
  output logic           BUSY
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned DEPTH = MUL_LAT + 1;
  localparam int unsigned TAG_W = DEPTH * IDX_W;

  logic [IDX_W-1:0] ptr;
  logic [15:0]      mul_a_q;
  logic [15:0]      mul_b_q;
  logic             mul_tc_q;
  logic [DEPTH-1:0] tag_v;
  logic [TAG_W-1:0] tag_idx;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [31:0]      rsp_product_q;
  logic             busy_q;

  logic             fire_c;
  logic [IDX_W-1:0] gidx_c;
  logic [N_REQ-1:0] grant_c;
  logic [IDX_W-1:0] last_idx;
  logic [15:0]      a_arr [N_REQ];
  logic [15:0]      b_arr [N_REQ];

  // Per-requester operand slices
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign a_arr[gi] = bus.REQ_A[gi*16 +: 16];
    assign b_arr[gi] = bus.REQ_B[gi*16 +: 16];
  end

  // Circular search from ptr for the first valid requester; gated by EN and reset
  always_comb begin
    int unsigned idx;
    fire_c = 1'b0;
    gidx_c = '0;
    idx    = 0;
    if (RSTN && EN) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = (32'(ptr) + k) % N_REQ;
        if (!fire_c && bus.REQ_VALID[IDX_W'(idx)]) begin
          fire_c = 1'b1;
          gidx_c = IDX_W'(idx);
        end
      end
    end
    grant_c = N_REQ'(fire_c) << gidx_c;
  end

  assign last_idx = tag_idx[TAG_W-1 -: IDX_W];

  // Pointer, issue registers, tag pipeline and response register
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ptr           <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_tc_q      <= 1'b0;
      tag_v         <= '0;
      tag_idx       <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      if (fire_c) begin
        ptr      <= (gidx_c == IDX_W'(N_REQ - 1)) ? '0 : gidx_c + IDX_W'(1);
        mul_a_q  <= a_arr[gidx_c];
        mul_b_q  <= b_arr[gidx_c];
        mul_tc_q <= bus.REQ_TC[gidx_c];
      end
      // Stage 0 takes the new tag; every stage shifts each cycle, no stall
      tag_v       <= DEPTH'({tag_v, fire_c});
      tag_idx     <= TAG_W'({tag_idx, gidx_c});
      rsp_valid_q <= tag_v[DEPTH-1] ? (N_REQ'(1) << last_idx) : '0;
      if (tag_v[DEPTH-1]) begin
        rsp_product_q <= bus.MUL_PRODUCT;
      end
      // Next-state OR of all tag valids and the response valid
      busy_q <= fire_c | (|tag_v);
    end
  end

  assign bus.REQ_READY   = grant_c;
  assign bus.MUL_A       = mul_a_q;
  assign bus.MUL_B       = mul_b_q;
  assign bus.MUL_TC      = mul_tc_q;
  assign bus.RSP_VALID   = rsp_valid_q;
  assign bus.RSP_PRODUCT = rsp_product_q;
  assign BUSY            = busy_q;
endmodule

// File: tb/tb_mul16_arbiter.sv
// Self-checking bench for mul16_arbiter: requester queues, a pipelined
// multiplier model, and a scoreboard of expected {owner, product, due cycle}.
module tb_mul16_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int QD  = 16;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        tc;
  } op_t;

  typedef struct {
    int          idx;
    logic [31:0] prod;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic en;
  logic busy;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;

  mul16_arbiter_if #(.N_REQ(N)) bus ();

  mul16_arbiter #(.N_REQ(N), .MUL_LAT(LAT)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .EN   (en),
    .bus  (bus),
    .BUSY (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Attached multiplier: LAT register stages from A/B/TC to PRODUCT
  logic [31:0] mpipe [LAT];

  function automatic logic [31:0] mul_hw(input logic [15:0] a, input logic [15:0] b, input logic tc);
    logic [31:0] ea, eb;
    ea = {(tc ? {16{a[15]}} : 16'h0000), a};
    eb = {(tc ? {16{b[15]}} : 16'h0000), b};
    return ea * eb;
  endfunction

  always @(posedge clk) begin
    mpipe[0] <= mul_hw(bus.MUL_A, bus.MUL_B, bus.MUL_TC);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign bus.MUL_PRODUCT = mpipe[LAT-1];

  // Reference product computed from the requester's own operands
  function automatic logic [31:0] prod_ref(input op_t o);
    longint x, y;
    if (o.tc) begin
      x = longint'($signed(o.a));
      y = longint'($signed(o.b));
    end else begin
      x = longint'({1'b0, o.a});
      y = longint'({1'b0, o.b});
    end
    return 32'(x * y);
  endfunction

  op_t          pend [N][QD];
  int           hd   [N];
  int           cnt  [N];
  logic [N-1:0] hs_mask = '0;
  int           m_ptr   = 0;
  exp_t         sb_q [$];
  int           glog [$];
  int           gcyc [$];
  int           rcyc [$];
  int           rwho [$];
  logic [N-1:0] last_rv = '0;
  logic [31:0]  last_rp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (cnt[i] > 0) begin
        bus.REQ_VALID[i]        = 1'b1;
        bus.REQ_A[16*i +: 16]   = pend[i][hd[i]].a;
        bus.REQ_B[16*i +: 16]   = pend[i][hd[i]].b;
        bus.REQ_TC[i]           = pend[i][hd[i]].tc;
      end else begin
        bus.REQ_VALID[i] = 1'b0;
      end
    end
  endtask

  task automatic push_op(input int i, input op_t o);
    pend[i][(hd[i] + cnt[i]) % QD] = o;
    cnt[i]++;
    drive();
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.a  = 16'($urandom);
    o.b  = 16'($urandom);
    o.tc = 1'($urandom_range(0, 1));
    return o;
  endfunction

  // Advance one clock; retire operands that handshook at this edge
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_mask[i] && cnt[i] > 0) begin
        hd[i] = (hd[i] + 1) % QD;
        cnt[i]--;
      end
    end
    drive();
  endtask

  function automatic bit idle();
    for (int i = 0; i < N; i++) if (cnt[i] != 0) return 1'b0;
    return sb_q.size() == 0;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (!idle() && n < 300) begin
      step();
      n++;
    end
    chk("drain_idle", 32'(idle()), 32'(1));
    step();
    step();
  endtask

  // Monitor: busy, responses against scoreboard, grants against round-robin model
  always @(negedge clk) begin : mon
    logic [N-1:0] eg;
    logic [N-1:0] hs;
    bit           found;
    int           j;
    int           who;
    exp_t         e;
    hs = '0;
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(sb_q.size() != 0));
      if (bus.RSP_VALID != '0) begin
        who = -1;
        for (int i = N - 1; i >= 0; i--) if (bus.RSP_VALID[i]) who = i;
        rcyc.push_back(cyc);
        rwho.push_back(who);
        last_rv = bus.RSP_VALID;
        last_rp = bus.RSP_PRODUCT;
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 32'(bus.RSP_VALID), 32'(0));
        end else begin
          e = sb_q.pop_front();
          chk("rsp_owner", 32'(bus.RSP_VALID), 32'(1) << e.idx);
          chk("rsp_product", bus.RSP_PRODUCT, e.prod);
          chk("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        chk("rsp_missing", 32'(bus.RSP_VALID), 32'(1) << e.idx);
      end

      eg    = '0;
      found = 1'b0;
      if (rstn && en) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!found && bus.REQ_VALID[j]) begin
            eg[j] = 1'b1;
            found = 1'b1;
          end
        end
      end
      chk("grant", 32'(bus.REQ_READY), 32'(eg));

      hs = rstn ? (bus.REQ_VALID & bus.REQ_READY) : '0;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          e.idx  = i;
          e.prod = prod_ref(pend[i][hd[i]]);
          e.due  = cyc + LAT + 2;
          sb_q.push_back(e);
          glog.push_back(i);
          gcyc.push_back(cyc);
          m_ptr = (i + 1) % N;
        end
      end
      if (!rstn) begin
        sb_q.delete();
        m_ptr = 0;
      end
    end
    hs_mask = hs;
  end

  initial begin
    int   n;
    int   rcount;
    int   fair_exp [4];
    op_t  o;
    fair_exp = '{3, 0, 3, 0};
    rstn = 1'b0;
    en   = 1'b1;
    bus.REQ_VALID = '0;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.REQ_TC    = '0;
    for (int i = 0; i < N; i++) begin
      hd[i]  = 0;
      cnt[i] = 0;
    end

    // Reset held two cycles with every requester valid
    for (int i = 0; i < N; i++) push_op(i, rand_op());
    #1;
    chk("rst_ready", 32'(bus.REQ_READY), 32'(0));
    step();
    chk_on = 1'b1;
    step();
    rstn = 1'b1;
    chk("rst_mul_a", 32'(bus.MUL_A), 32'(0));
    chk("rst_mul_b", 32'(bus.MUL_B), 32'(0));
    chk("rst_mul_tc", 32'(bus.MUL_TC), 32'(0));
    chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    glog.delete();
    step();
    chk("rst_first_grant", 32'(glog.size() > 0 ? glog[0] : -1), 32'(0));
    drain();

    // Single op from requester 1, signed then unsigned
    o.a = 16'hFFFF; o.b = 16'h0002; o.tc = 1'b1;
    push_op(1, o);
    drain();
    chk("single_signed_owner", 32'(last_rv), 32'h2);
    chk("single_signed_prod", last_rp, 32'hFFFF_FFFE);
    o.tc = 1'b0;
    push_op(1, o);
    drain();
    chk("single_unsigned_owner", 32'(last_rv), 32'h2);
    chk("single_unsigned_prod", last_rp, 32'h0001_FFFE);

    // Full load: all requesters continuously valid, 12 ops
    glog.delete(); gcyc.delete(); rcyc.delete(); rwho.delete();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push_op(i, rand_op());
    drain();
    chk("load_grants", 32'(glog.size()), 32'(12));
    if (glog.size() > 0) chk("load_first", 32'(glog[0]), 32'(2));
    for (int k = 1; k < glog.size(); k++) begin
      chk("load_rr_order", 32'(glog[k]), 32'((glog[k-1] + 1) % N));
      chk("load_grant_gap", 32'(gcyc[k]), 32'(gcyc[k-1] + 1));
    end
    chk("load_rsps", 32'(rcyc.size()), 32'(12));
    for (int k = 1; k < rcyc.size(); k++) begin
      chk("load_rsp_gap", 32'(rcyc[k]), 32'(rcyc[k-1] + 1));
      if (k < glog.size()) chk("load_rsp_order", 32'(rwho[k]), 32'(glog[k]));
    end

    // Fairness: after a grant to 2, only requesters 0 and 3 compete
    push_op(2, rand_op());
    drain();
    glog.delete();
    push_op(0, rand_op()); push_op(3, rand_op());
    push_op(0, rand_op()); push_op(3, rand_op());
    drain();
    chk("fair_grants", 32'(glog.size()), 32'(4));
    for (int k = 0; k < 4 && k < glog.size(); k++) chk("fair_order", 32'(glog[k]), 32'(fair_exp[k]));

    // EN gating with three ops in flight
    glog.delete(); rcyc.delete();
    for (int i = 0; i < 3; i++) push_op(i, rand_op());
    n = 0;
    while (glog.size() < 3 && n < 20) begin step(); n++; end
    en = 1'b0;
    for (int i = 0; i < N; i++) push_op(i, rand_op());
    repeat (8) step();
    chk("en_no_grant", 32'(glog.size()), 32'(3));
    chk("en_rsps", 32'(rcyc.size()), 32'(3));
    chk("en_busy_low", 32'(busy), 32'(0));
    en = 1'b1;
    drain();

    // Reset with two ops in flight
    glog.delete();
    push_op(1, rand_op()); push_op(2, rand_op());
    n = 0;
    while (glog.size() < 2 && n < 20) begin step(); n++; end
    rstn   = 1'b0;
    rcount = rcyc.size();
    step();
    chk("rstmid_busy", 32'(busy), 32'(0));
    chk("rstmid_rsp_valid", 32'(bus.RSP_VALID), 32'(0));
    rstn = 1'b1;
    repeat (8) step();
    chk("rstmid_no_rsp", 32'(rcyc.size()), 32'(rcount));

    // Random traffic with random EN
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (cnt[i] < 2 && $urandom_range(0, 2) == 0) push_op(i, rand_op());
      step();
    end
    en = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
